// File: rtl/clock_timekeeper.sv
// 12-hour timekeeping core: 1 Hz prescaler, HH:MM:SS counters, two-button set mode
// with on-chip synchronisers and debouncers. Define PM_IND_EN to add the registered pm output.
module clock_timekeeper #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] set_mode,
  output logic       tick_1hz
`ifdef PM_IND_EN
  ,
  output logic       pm
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } mode_e;

  localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Button conditioning; bit 0 = mode, bit 1 = inc
  // ---------------------------------------------------------------------------
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d;
  logic [1:0]      press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  assign btn_raw = {btn_inc, btn_mode};

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int b = 0; b < 2; b++) begin
      db_cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        // DB_CYCLES consecutive differing samples accept the new level
        if (db_cnt_q[b] == DB_LAST) begin
          deb_d[b]   = sync2_q[b];
          press_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= db_cnt_d[b];
    end
  end

  logic mode_press, inc_press;
  assign mode_press = press_q[0];
  assign inc_press  = press_q[1];

  // ---------------------------------------------------------------------------
  // Mode FSM, prescaler and time counters
  // ---------------------------------------------------------------------------
  mode_e           state_q;
  logic [PS_W-1:0] presc_q;
  logic            tick_q;
  logic [3:0]      hour_q, hour_next;
  logic [5:0]      min_q, min_next;
  logic [5:0]      sec_q, sec_next;
  logic            wrap;
`ifdef PM_IND_EN
  logic            pm_q;
`endif

  assign hour_next = (hour_q == 4'd12) ? 4'd1 : hour_q + 4'd1;
  assign min_next  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
  assign sec_next  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
  assign wrap      = (presc_q == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      presc_q <= '0;
      tick_q  <= 1'b0;
      hour_q  <= 4'd12;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
`ifdef PM_IND_EN
      pm_q    <= 1'b0;
`endif
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (wrap) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
            sec_q   <= sec_next;
            if (sec_q == 6'd59) begin
              min_q <= min_next;
              if (min_q == 6'd59) begin
                hour_q <= hour_next;
`ifdef PM_IND_EN
                if (hour_q == 4'd11) pm_q <= ~pm_q;
`endif
              end
            end
          end else begin
            presc_q <= presc_q + PS_W'(1);
          end
          // A tick on the same edge still lands; the prescaler then parks at 0
          if (mode_press) begin
            state_q <= ST_SET_HOUR;
            presc_q <= '0;
          end
        end
        ST_SET_HOUR: begin
          presc_q <= '0;
          if (mode_press) begin
            state_q <= ST_SET_MIN;
          end else if (inc_press) begin
            hour_q <= hour_next;
`ifdef PM_IND_EN
            if (hour_q == 4'd11) pm_q <= ~pm_q;
`endif
          end
        end
        ST_SET_MIN: begin
          presc_q <= '0;
          if (mode_press) begin
            state_q <= ST_RUN;
            sec_q   <= 6'd0;
          end else if (inc_press) begin
            min_q <= min_next;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign hour     = hour_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign set_mode = state_q;
  assign tick_1hz = tick_q;
`ifdef PM_IND_EN
  assign pm       = pm_q;
`endif

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper with CLK_HZ=10, DB_CYCLES=4; drives and samples on negedge.
module tb_clock_timekeeper;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] set_mode;
  logic       tick_1hz;
`ifdef PM_IND_EN
  logic       pm;
`endif

  int checks = 0;
  int errors = 0;
  int ticks, badpos, changes, first_tick;
  logic [1:0] prev_mode;

  always #5 clk = ~clk;

  clock_timekeeper #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hour     (hour),
    .min      (min),
    .sec      (sec),
    .set_mode (set_mode),
    .tick_1hz (tick_1hz)
`ifdef PM_IND_EN
    ,
    .pm       (pm)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the buttons long enough to debounce, then release and let the release settle
  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    cycles(9);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cycles(9);
  endtask

  task automatic wait_ticks(input int n, input int budget, input string tag);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (tick_1hz) seen++;
    end
    check(tag, seen, n);
  endtask

  task automatic track_mode(input int n);
    repeat (n) begin
      @(negedge clk);
      if (set_mode !== prev_mode) changes++;
      prev_mode = set_mode;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cycles(3);
    check("reset_hour", hour, 12);
    check("reset_min", min, 0);
    check("reset_sec", sec, 0);
    check("reset_mode", set_mode, 0);
    check("reset_tick", tick_1hz, 0);
`ifdef PM_IND_EN
    check("reset_pm", pm, 0);
`endif
    rst = 1'b0;

    // 600 cycles of RUN: 60 ticks, one on every 10th edge
    ticks  = 0;
    badpos = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (tick_1hz) ticks++;
      if (tick_1hz !== (k % 10 == 0)) badpos++;
    end
    check("run_tick_count", ticks, 60);
    check("run_tick_spacing", badpos, 0);
    check("run_hour", hour, 12);
    check("run_min", min, 1);
    check("run_sec", sec, 0);

    cycles(35);
    check("run_sec_35", sec, 3);

    // Enter SET_HOUR; the tick at edge 640 lands before the mode change
    press(1'b1, 1'b0);
    check("enter_set_hour", set_mode, 1);
    check("enter_set_hour_sec", sec, 4);
    ticks = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tick_1hz) ticks++;
    end
    check("set_hour_no_tick", ticks, 0);
    check("set_hour_sec_frozen", sec, 4);

    for (int k = 1; k <= 12; k++) begin
      press(1'b0, 1'b1);
      check($sformatf("set_hour_seq_%0d", k), hour, k);
    end
`ifdef PM_IND_EN
    check("pm_after_11_to_12", pm, 1);
`endif

    // Mode and inc debounced together: mode wins
    press(1'b1, 1'b1);
    check("same_cycle_mode", set_mode, 2);
    check("same_cycle_hour", hour, 12);

    for (int k = 0; k < 58; k++) press(1'b0, 1'b1);
    check("set_min_59", min, 59);
    press(1'b0, 1'b1);
    check("set_min_wrap", min, 0);
    check("set_min_wrap_hour", hour, 12);
    for (int k = 0; k < 59; k++) press(1'b0, 1'b1);
    check("set_min_59_again", min, 59);

    // Back to RUN: sec cleared, first tick 10 cycles after the transition
    press(1'b1, 1'b0);
    check("back_to_run", set_mode, 0);
    check("back_to_run_sec", sec, 1);
    wait_ticks(58, 700, "carry_wait_59");
    check("pre_carry_hour", hour, 12);
    check("pre_carry_min", min, 59);
    check("pre_carry_sec", sec, 59);
    wait_ticks(1, 20, "carry_wait_tick");
    check("carry_hour", hour, 1);
    check("carry_min", min, 0);
    check("carry_sec", sec, 0);
`ifdef PM_IND_EN
    check("carry_pm_unchanged", pm, 1);
`endif

    // btn_inc held in RUN changes nothing
    btn_inc = 1'b1;
    cycles(30);
    btn_inc = 1'b0;
    cycles(9);
    check("run_inc_hour", hour, 1);
    check("run_inc_min", min, 0);
    check("run_inc_mode", set_mode, 0);

    // Bouncing mode button, then a clean hold: one press only
    changes   = 0;
    prev_mode = set_mode;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) btn_mode = ~btn_mode;
      track_mode(1);
    end
    btn_mode = 1'b1;
    track_mode(12);
    btn_mode = 1'b0;
    track_mode(9);
    check("bounce_changes", changes, 1);
    check("bounce_mode", set_mode, 1);

    // 3-cycle glitch is shorter than the debounce window
    btn_mode = 1'b1;
    track_mode(3);
    btn_mode = 1'b0;
    track_mode(12);
    check("glitch_changes", changes, 1);
    check("glitch_mode", set_mode, 1);

    press(1'b1, 1'b0);
    check("to_set_min", set_mode, 2);
    for (int k = 0; k < 37; k++) press(1'b0, 1'b1);
    check("set_min_37", min, 37);
    check("set_min_37_hour", hour, 1);

    // Synchronous reset from SET_MIN
    rst = 1'b1;
    cycles(1);
    check("rst_hour", hour, 12);
    check("rst_min", min, 0);
    check("rst_sec", sec, 0);
    check("rst_mode", set_mode, 0);
    check("rst_tick", tick_1hz, 0);
`ifdef PM_IND_EN
    check("rst_pm", pm, 0);
`endif
    rst        = 1'b0;
    first_tick = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (tick_1hz && first_tick < 0) first_tick = k;
    end
    check("rst_first_tick", first_tick, 10);
    check("rst_sec_after", sec, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
